// File: rtl/dispatch_arbiter.sv
// dispatch_arbiter: round-robin pick of one ready scoreboard per cycle into a single issue register
// feeding the functional units under a valid/ready handshake.
module dispatch_arbiter #(
    parameter int NUM_SB = 4,
    parameter int NUM_FU = 2,
    parameter int FU_W   = 2,
    parameter int FC_W   = 5,
    parameter int VREG_W = 5,
    parameter int DWIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_SB-1:0]          sbReady_i,
    input  logic [NUM_SB*FU_W-1:0]     sbFuncUnit_i,
    input  logic [NUM_SB*FC_W-1:0]     sbFuncCode_i,
    input  logic [NUM_SB*VREG_W-1:0]   sbVrdIdx_i,
    input  logic [NUM_SB-1:0]          sbHasRd_i,
    input  logic [NUM_SB-1:0]          sbRdType_i,
    input  logic [NUM_SB-1:0]          sbHasImm_i,
    input  logic [NUM_SB*DWIDTH-1:0]   sbImm_i,
    output logic [NUM_SB-1:0]          dispatchAck_o,
    input  logic [NUM_FU-1:0]          fuReady_i,
    output logic                       issueValid_o,
    output logic [FU_W-1:0]            issueFu_o,
    output logic [$clog2(NUM_SB)-1:0]  issueThread_o,
    output logic [FC_W-1:0]            issueFuncCode_o,
    output logic [VREG_W-1:0]          issueVrd_o,
    output logic                       issueHasRd_o,
    output logic                       issueRdType_o,
    output logic                       issueHasImm_o,
    output logic [DWIDTH-1:0]          issueImm_o,
    output logic [31:0]                issueCount_o,
    output logic                       errIllegalFu_o
);
    localparam int TW = $clog2(NUM_SB);

    typedef struct packed {
        logic [FU_W-1:0]   fu;
        logic [TW-1:0]     thread;
        logic [FC_W-1:0]   fc;
        logic [VREG_W-1:0] vrd;
        logic              has_rd;
        logic              rd_type;
        logic              has_imm;
        logic [DWIDTH-1:0] imm;
    } op_t;

    op_t           op_q, op_d, win_op;
    logic          valid_q, valid_d;
    logic [TW-1:0] rr_q, rr_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          fu_ok, fire, can_load, grant, legal, has_hi;
    logic [TW-1:0] win, win_hi, win_lo;

    always_comb begin
        fu_ok = 1'b0;
        for (int i = 0; i < NUM_FU; i++)
            if (int'(op_q.fu) == i) fu_ok = fuReady_i[i];
        fire     = valid_q && fu_ok;
        can_load = !valid_q || fire;
        grant    = rstn && can_load && |sbReady_i;
    end

    // Downward scan leaves the lowest ready index at/above the pointer and the lowest one below it.
    always_comb begin
        has_hi = 1'b0;
        win_hi = '0;
        win_lo = '0;
        for (int j = NUM_SB - 1; j >= 0; j--)
            if (sbReady_i[j]) begin
                if (j >= int'(rr_q)) begin
                    win_hi = TW'(j);
                    has_hi = 1'b1;
                end else begin
                    win_lo = TW'(j);
                end
            end
        win = has_hi ? win_hi : win_lo;
    end

    always_comb begin
        win_op = '0;
        for (int j = 0; j < NUM_SB; j++)
            if (win == TW'(j)) begin
                win_op.fu      = sbFuncUnit_i[j*FU_W +: FU_W];
                win_op.thread  = TW'(j);
                win_op.fc      = sbFuncCode_i[j*FC_W +: FC_W];
                win_op.vrd     = sbVrdIdx_i[j*VREG_W +: VREG_W];
                win_op.has_rd  = sbHasRd_i[j];
                win_op.rd_type = sbRdType_i[j];
                win_op.has_imm = sbHasImm_i[j];
                win_op.imm     = sbImm_i[j*DWIDTH +: DWIDTH];
            end
        legal = int'(win_op.fu) < NUM_FU;
    end

    // An illegal winner is still acked so its scoreboard is released, but never reaches the issue register.
    always_comb begin
        op_d          = (grant && legal) ? win_op : op_q;
        valid_d       = (grant && legal) || (valid_q && !fire);
        rr_d          = grant ? ((int'(win) == NUM_SB - 1) ? '0 : win + 1'b1) : rr_q;
        cnt_d         = cnt_q + 32'(fire);
        err_d         = err_q || (grant && !legal);
        dispatchAck_o = grant ? (NUM_SB'(1) << win) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_q    <= '0;
            valid_q <= 1'b0;
            rr_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            op_q    <= op_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign issueValid_o    = valid_q;
    assign issueFu_o       = op_q.fu;
    assign issueThread_o   = op_q.thread;
    assign issueFuncCode_o = op_q.fc;
    assign issueVrd_o      = op_q.vrd;
    assign issueHasRd_o    = op_q.has_rd;
    assign issueRdType_o   = op_q.rd_type;
    assign issueHasImm_o   = op_q.has_imm;
    assign issueImm_o      = op_q.imm;
    assign issueCount_o    = cnt_q;
    assign errIllegalFu_o  = err_q;
endmodule

// File: tb/tb_dispatch_arbiter.sv
// tb_dispatch_arbiter: randomized + directed stimulus scored against a queue-based reference model;
// a small NUM_SB=3 instance checks the wrap of the round-robin pointer.
module tb_dispatch_arbiter;
    localparam int NSB = 4;
    localparam int NFU = 2;

    logic clk = 1'b0, rstn = 1'b0, rstn3 = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]   sbReady, sbHasRd, sbRdType, sbHasImm, ack;
    logic [7:0]   sbFuncUnit;
    logic [19:0]  sbFuncCode, sbVrdIdx;
    logic [127:0] sbImm;
    logic [1:0]   fuReady, issueFu, issueThread;
    logic         issueValid, issueHasRd, issueRdType, issueHasImm, errFu;
    logic [4:0]   issueFc, issueVrd;
    logic [31:0]  issueImm, issueCount;

    logic [2:0]  ack3;
    logic        v3, hrd3, rdt3, him3, err3;
    logic [1:0]  fu3, th3;
    logic [4:0]  fc3, vrd3;
    logic [31:0] imm3, cnt3;

    dispatch_arbiter u_dut (
        .clk(clk), .rstn(rstn), .sbReady_i(sbReady), .sbFuncUnit_i(sbFuncUnit),
        .sbFuncCode_i(sbFuncCode), .sbVrdIdx_i(sbVrdIdx), .sbHasRd_i(sbHasRd),
        .sbRdType_i(sbRdType), .sbHasImm_i(sbHasImm), .sbImm_i(sbImm),
        .dispatchAck_o(ack), .fuReady_i(fuReady), .issueValid_o(issueValid),
        .issueFu_o(issueFu), .issueThread_o(issueThread), .issueFuncCode_o(issueFc),
        .issueVrd_o(issueVrd), .issueHasRd_o(issueHasRd), .issueRdType_o(issueRdType),
        .issueHasImm_o(issueHasImm), .issueImm_o(issueImm), .issueCount_o(issueCount),
        .errIllegalFu_o(errFu)
    );

    dispatch_arbiter #(.NUM_SB(3)) u_dut3 (
        .clk(clk), .rstn(rstn3), .sbReady_i(3'b111), .sbFuncUnit_i(6'b0),
        .sbFuncCode_i(15'b0), .sbVrdIdx_i(15'b0), .sbHasRd_i(3'b0),
        .sbRdType_i(3'b0), .sbHasImm_i(3'b0), .sbImm_i(96'b0),
        .dispatchAck_o(ack3), .fuReady_i(2'b11), .issueValid_o(v3),
        .issueFu_o(fu3), .issueThread_o(th3), .issueFuncCode_o(fc3),
        .issueVrd_o(vrd3), .issueHasRd_o(hrd3), .issueRdType_o(rdt3),
        .issueHasImm_o(him3), .issueImm_o(imm3), .issueCount_o(cnt3),
        .errIllegalFu_o(err3)
    );

    typedef struct packed {
        logic [3:0]  ack;
        logic        valid;
        logic [31:0] count;
        logic        err;
    } exp_t;
    typedef logic [48:0] op_t;

    exp_t exp_q[$];
    op_t  exp_ops[$];
    int   n_chk = 0, n_pass = 0;

    logic        s_rstn = 1'b1;
    logic [3:0]  s_rdy = '0;
    logic [1:0]  s_fr = '0;
    logic [1:0]  s_fu[NSB] = '{default: 2'd0};
    logic        m_valid = 1'b0, m_err = 1'b0;
    op_t         m_op = '0;
    int          m_rr = 0;
    logic [31:0] m_count = '0;
    logic [3:0]  last_ack = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        exp_t e;
        int   w;
        int   fu;
        logic fire;
        @(negedge clk);
        rstn = s_rstn;
        sbReady = s_rdy;
        fuReady = s_fr;
        for (int i = 0; i < NSB; i++) begin
            sbFuncUnit[i*2 +: 2]  = s_fu[i];
            sbFuncCode[i*5 +: 5]  = 5'($urandom);
            sbVrdIdx[i*5 +: 5]    = 5'($urandom);
            sbHasRd[i]            = 1'($urandom);
            sbRdType[i]           = 1'($urandom);
            sbHasImm[i]           = 1'($urandom);
            sbImm[i*32 +: 32]     = $urandom;
        end
        e = '{ack: 4'b0, valid: m_valid, count: m_count, err: m_err};
        if (!s_rstn) begin
            m_valid = 1'b0; m_rr = 0; m_count = '0; m_err = 1'b0; m_op = '0;
            exp_ops.delete();
        end else begin
            fu   = int'(m_op[48:47]);
            fire = m_valid && fu < NFU && s_fr[fu];
            w = -1;
            if (!m_valid || fire)
                for (int k = 0; k < NSB; k++) begin
                    int i = (m_rr + k) % NSB;
                    if (w < 0 && s_rdy[i]) w = i;
                end
            if (w >= 0) begin
                e.ack = 4'(1 << w);
                m_rr = (w + 1) % NSB;
                if (int'(s_fu[w]) < NFU) begin
                    m_op = {s_fu[w], 2'(w), sbFuncCode[w*5 +: 5], sbVrdIdx[w*5 +: 5],
                            sbHasRd[w], sbRdType[w], sbHasImm[w], sbImm[w*32 +: 32]};
                    exp_ops.push_back(m_op);
                    m_valid = 1'b1;
                end else begin
                    m_err = 1'b1;
                    m_valid = 1'b0;
                end
            end else if (fire) m_valid = 1'b0;
            if (fire) m_count++;
        end
        last_ack = e.ack;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        s_rdy = '0;
        s_fr = 2'b11;
        repeat (n) step();
    endtask

    exp_t mon_e;
    op_t  mon_o;
    always begin
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("ack", ack, mon_e.ack);
            chk("issue_valid", issueValid, mon_e.valid);
            chk("issue_count", issueCount, mon_e.count);
            chk("err_illegal_fu", errFu, mon_e.err);
        end
        if (rstn && issueValid && issueFu < 2 && fuReady[issueFu]) begin
            chk("fire_expected", 64'(exp_ops.size() != 0), 64'd1);
            if (exp_ops.size() != 0) begin
                mon_o = exp_ops.pop_front();
                chk("issue_op", {issueFu, issueThread, issueFc, issueVrd, issueHasRd,
                                 issueRdType, issueHasImm, issueImm}, mon_o);
            end
        end
    end

    initial begin
        sbReady = 4'b1111; fuReady = 2'b11; sbFuncUnit = '0; sbFuncCode = '0;
        sbVrdIdx = '0; sbHasRd = '0; sbRdType = '0; sbHasImm = '0; sbImm = '0;
        repeat (3) @(negedge clk);
        chk("rst_issue", {issueValid, issueFu, issueThread, issueFc, issueVrd, issueHasRd,
                          issueRdType, issueHasImm, issueImm}, 64'd0);
        chk("rst_count", issueCount, 64'd0);
        chk("rst_err", errFu, 64'd0);
        chk("rst_ack_gated", ack, 64'd0);
        chk("rst_ack3_gated", ack3, 64'd0);
        rstn3 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("nsb3_rr_ack", ack3, 64'(1 << (i % 3)));
            @(negedge clk);
        end
        // fairness: all ready, no stall
        s_rdy = 4'b1111; s_fr = 2'b11;
        repeat (5) step();
        idle(2);
        // backpressure on the float unit
        s_fu[2] = 2'd1; s_rdy = 4'b0100; s_fr = 2'b01; step();
        s_rdy = '0; repeat (3) step();
        s_fr = 2'b11; step();
        // pointer now past 2: wrap to 0
        s_fu[0] = 2'd0; s_rdy = 4'b0101; step();
        idle(2);
        // illegal unit released but never issued; flag stays
        s_fu[1] = 2'd3; s_rdy = 4'b0010; step();
        s_fu[1] = 2'd0; s_rdy = 4'b1011; step();
        idle(3);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NSB; i++)
                s_fu[i] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            s_rdy = 4'($urandom) & ~last_ack;
            s_fr = 2'($urandom);
            step();
        end
        idle(3);
        // reset while an operation is held under backpressure
        s_fu[0] = 2'd1; s_rdy = 4'b0001; s_fr = 2'b00; step();
        s_rdy = '0; step();
        s_rstn = 1'b0; s_rdy = 4'b1111; step();
        s_rstn = 1'b1; s_fu[1] = 2'd0; s_fu[3] = 2'd0; s_rdy = 4'b1010; s_fr = 2'b11; step();
        idle(3);
        @(negedge clk);
        #2;
        chk("ops_drained", 64'(exp_ops.size()), 64'd0);
        chk("exp_drained", 64'(exp_q.size()), 64'd0);
        chk("final_count", issueCount, m_count);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
